// File: rtl/alu_exec_unit.sv
// +----------------------------------------------------------------------------+
// | alu_exec_unit: registered ALU with decode and iterative multu (hi/lo).     |
// | Optional: ALU_OVF_EN adds the signed-overflow output ovf.   Rev 1.0        |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_exec_unit #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       ALUOp,
   input  logic [5:0]       funct,
   input  logic [5:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             illegal
`ifdef ALU_OVF_EN
   ,output logic            ovf
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
      OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_MULTU
   } op_t;

   state_t              state, state_nxt;
   op_t                 dec_op;
   logic                dec_illegal;
   logic                accept;
   logic [WIDTH-1:0]    alu_res;
   logic [SHW-1:0]      shamt;
   logic [WIDTH-1:0]    mcand;
   logic [2*WIDTH-1:0]  prod, prod_nxt;
   logic [WIDTH:0]      psum;
   logic [SHW:0]        cnt;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign accept    = in_valid & in_ready;
   assign zero      = (result == '0);
   assign shamt     = b[SHW-1:0];

   always_comb begin
      dec_op      = OP_ADD;
      dec_illegal = 1'b0;
      case (ALUOp)
         2'b00: dec_op = OP_ADD;
         2'b01: dec_op = OP_SUB;
         2'b10: begin
            case (funct)
               6'b100000, 6'b100001: dec_op = OP_ADD;
               6'b100010, 6'b100011: dec_op = OP_SUB;
               6'b100100:            dec_op = OP_AND;
               6'b100101:            dec_op = OP_OR;
               6'b100110:            dec_op = OP_XOR;
               6'b100111:            dec_op = OP_NOR;
               6'b101010:            dec_op = OP_SLT;
               6'b101011:            dec_op = OP_SLTU;
               6'b000000:            dec_op = OP_SLL;
               6'b000010:            dec_op = OP_SRL;
               6'b000011:            dec_op = OP_SRA;
               6'b011001:            dec_op = OP_MULTU;
               default:              dec_illegal = 1'b1;
            endcase
         end
         default: begin
            case (opcode)
               6'b001100: dec_op = OP_AND;
               6'b001101: dec_op = OP_OR;
               6'b001110: dec_op = OP_XOR;
               6'b001010: dec_op = OP_SLT;
               6'b001011: dec_op = OP_SLTU;
               6'b001111: dec_op = OP_LUI;
               default:   dec_illegal = 1'b1;
            endcase
         end
      endcase
   end

   always_comb begin
      alu_res = '0;
      case (dec_op)
         OP_ADD:  alu_res = a + b;
         OP_SUB:  alu_res = a - b;
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_NOR:  alu_res = ~(a | b);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLL:  alu_res = a << shamt;
         OP_SRL:  alu_res = a >> shamt;
         OP_SRA:  alu_res = $signed(a) >>> shamt;
         OP_LUI:  alu_res = b << (WIDTH/2);
         default: alu_res = '0;
      endcase
   end

`ifdef ALU_OVF_EN
   // Only the trapping add/sub encodings flag overflow; addu/subu never do.
   logic ovf_chk, ovf_v;
   always_comb begin
      ovf_chk = (ALUOp == 2'b00) || (ALUOp == 2'b01) ||
                ((ALUOp == 2'b10) && ((funct == 6'b100000) || (funct == 6'b100010)));
      ovf_v   = 1'b0;
      if (ovf_chk && dec_op == OP_ADD)
         ovf_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      else if (ovf_chk && dec_op == OP_SUB)
         ovf_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
   end
`endif

   // Shift-add step: conditionally add multiplicand to the upper half, then shift right.
   always_comb begin
      psum     = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                 (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      prod_nxt = {psum, prod[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = (dec_op == OP_MULTU) ? S_BUSY : S_DONE;
         S_BUSY:  if (cnt == (SHW+1)'(1)) state_nxt = S_DONE;
         S_DONE:  if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result  <= '0;
         hi      <= '0;
         illegal <= 1'b0;
         mcand   <= '0;
         prod    <= '0;
         cnt     <= '0;
`ifdef ALU_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  illegal <= dec_illegal;
`ifdef ALU_OVF_EN
                  ovf     <= ovf_v;
`endif
                  if (dec_op == OP_MULTU) begin
                     mcand <= a;
                     prod  <= {{WIDTH{1'b0}}, b};
                     cnt   <= (SHW+1)'(WIDTH);
                  end else begin
                     result <= alu_res;
                     hi     <= '0;
                  end
               end
            end
            S_BUSY: begin
               prod <= prod_nxt;
               cnt  <= cnt - (SHW+1)'(1);
               if (cnt == (SHW+1)'(1)) begin
                  hi     <= prod_nxt[2*WIDTH-1:WIDTH];
                  result <= prod_nxt[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// +----------------------------------------------------------------------------+
// | tb_alu_exec_unit: directed self-checking bench for alu_exec_unit. Rev 1.0  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  ALUOp = 2'b00;
   logic [5:0]  funct = 6'b0;
   logic [5:0]  opcode = 6'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic [31:0] hi;
   logic        zero;
   logic        illegal;
`ifdef ALU_OVF_EN
   logic        ovf;
`endif

   int checks = 0;
   int errors = 0;

   alu_exec_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ALUOp     (ALUOp),
      .funct     (funct),
      .opcode    (opcode),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .hi        (hi),
      .zero      (zero),
      .illegal   (illegal)
`ifdef ALU_OVF_EN
      ,.ovf      (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [5:0] oc,
                        input logic [31:0] av, input logic [31:0] bv);
      ALUOp = op; funct = fn; opcode = oc; a = av; b = bv;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("idle_ready", {63'd0, in_ready}, 64'd1);
   endtask

   task automatic run_single(input string tag, input logic [1:0] op, input logic [5:0] fn,
                             input logic [5:0] oc, input logic [31:0] av, input logic [31:0] bv,
                             input logic [31:0] exp_res, input logic exp_ill);
      issue(op, fn, oc, av, bv);
      check({tag, "_valid"},   {63'd0, out_valid}, 64'd1);
      check({tag, "_result"},  {32'd0, result},    {32'd0, exp_res});
      check({tag, "_hi"},      {32'd0, hi},        64'd0);
      check({tag, "_zero"},    {63'd0, zero},      {63'd0, (exp_res == 32'd0)});
      check({tag, "_illegal"}, {63'd0, illegal},   {63'd0, exp_ill});
      release_out();
   endtask

   task automatic run_multu(input string tag, input logic [31:0] av, input logic [31:0] bv);
      int k;
      logic busy_ok;
      logic [63:0] exp_p;
      exp_p = {32'd0, av} * {32'd0, bv};
      issue(2'b10, 6'b011001, 6'b0, av, bv);
      k = 0;
      busy_ok = 1'b1;
      while (!out_valid && k < 100) begin
         if (in_ready) busy_ok = 1'b0;
         tick();
         k++;
      end
      check({tag, "_busy_ready"}, {63'd0, busy_ok}, 64'd1);
      check({tag, "_latency"},    64'(k),           64'd32);
      check({tag, "_product"},    {hi, result},     exp_p);
   endtask

   initial begin
      // Reset held two cycles.
      tick();
      tick();
      check("rst_in_ready",  {63'd0, in_ready},  64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_result",    {32'd0, result},    64'd0);
      check("rst_zero",      {63'd0, zero},      64'd1);
      check("rst_hi",        {32'd0, hi},        64'd0);
      reset = 1'b0;
      tick();

      run_single("add",   2'b10, 6'b100000, 6'b0, 32'd5, 32'd7, 32'd12, 1'b0);
      run_single("xori",  2'b11, 6'b0, 6'b001110, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0);
      run_single("slti",  2'b11, 6'b0, 6'b001010, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
      run_single("sltiu", 2'b11, 6'b0, 6'b001011, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
      run_single("sra",   2'b10, 6'b000011, 6'b0, 32'h80000000, 32'd4, 32'hF8000000, 1'b0);
      run_single("srl",   2'b10, 6'b000010, 6'b0, 32'h80000000, 32'd4, 32'h08000000, 1'b0);
      run_single("sll31", 2'b10, 6'b000000, 6'b0, 32'd1, 32'd31, 32'h80000000, 1'b0);
      run_single("sllw",  2'b10, 6'b000000, 6'b0, 32'd1, 32'd33, 32'd2, 1'b0);
      run_single("sub01", 2'b01, 6'b0, 6'b0, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0);
      run_single("nor",   2'b10, 6'b100111, 6'b0, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0);
      run_single("lui",   2'b11, 6'b0, 6'b001111, 32'd0, 32'h00001234, 32'h12340000, 1'b0);
      run_single("slt",   2'b10, 6'b101010, 6'b0, 32'd3, 32'hFFFFFFFE, 32'd0, 1'b0);
      run_single("ori",   2'b11, 6'b0, 6'b001101, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0);

      // Multiply with backpressure; a conflicting op held on in_valid must be ignored.
      run_multu("mul", 32'hFFFFFFFF, 32'd2);
      check("mul_hi", {32'd0, hi},     64'd1);
      check("mul_lo", {32'd0, result}, 64'hFFFFFFFE);
      ALUOp = 2'b10; funct = 6'b100000; a = 32'd1; b = 32'd1; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_valid", {63'd0, out_valid}, 64'd1);
         check("hold_prod",  {hi, result},      64'h00000001_FFFFFFFE);
      end
      in_valid = 1'b0;
      release_out();
      check("post_mul_valid", {63'd0, out_valid}, 64'd0);

      run_multu("mul2", 32'h12345678, 32'h9ABCDEF0);
      release_out();
      run_single("add_after_mul", 2'b00, 6'b0, 6'b0, 32'd100, 32'd23, 32'd123, 1'b0);

      run_single("ill_funct",  2'b10, 6'b111111, 6'b0, 32'd10, 32'd20, 32'd30, 1'b1);
      run_single("ill_opcode", 2'b11, 6'b0, 6'b000000, 32'd1, 32'd2, 32'd3, 1'b1);

      // Reset asserted during BUSY cycle 10 abandons the multiply.
      issue(2'b10, 6'b011001, 6'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (9) tick();
      check("mid_busy", {63'd0, in_ready}, 64'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mrst_in_ready",  {63'd0, in_ready},  64'd1);
      check("mrst_out_valid", {63'd0, out_valid}, 64'd0);
      check("mrst_hi",        {32'd0, hi},        64'd0);
      check("mrst_result",    {32'd0, result},    64'd0);
      repeat (3) tick();
      check("mrst_stays_idle", {63'd0, out_valid}, 64'd0);
      run_single("add_after_rst", 2'b10, 6'b100001, 6'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);

`ifdef ALU_OVF_EN
      issue(2'b10, 6'b100000, 6'b0, 32'h7FFFFFFF, 32'd1);
      check("ovf_add",     {63'd0, ovf},    64'd1);
      check("ovf_add_res", {32'd0, result}, 64'h80000000);
      release_out();
      issue(2'b10, 6'b100001, 6'b0, 32'h7FFFFFFF, 32'd1);
      check("ovf_addu",    {63'd0, ovf},    64'd0);
      release_out();
      issue(2'b01, 6'b0, 6'b0, 32'h80000000, 32'd1);
      check("ovf_sub",     {63'd0, ovf},    64'd1);
      release_out();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised, handshaked successor to the combinational ALU-control decode. It folds the ALUOp/funct/opcode decode and the ALU datapath into one registered execution unit. Single-cycle ops (logic, arith, compare, shift) sit alongside an iterative unsigned multiplier (multu) that returns hi/lo. It sits between register read and writeback in the multi-cycle core, stalling the front end through in_ready while a multiply runs.

Parameters:
WIDTH, 32, datapath width in bits; must be an even power of two, >= 8.
SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operation presented.
in_ready  output  1  unit can accept an operation.
ALUOp  input  2  00 add, 01 sub, 10 R-type (use funct), 11 immediate (use opcode).
funct  input  6  R-type function field.
opcode  input  6  instruction opcode.
a  input  WIDTH  operand A (rs).
b  input  WIDTH  operand B (rt or extended immediate); shifts use b[SHW-1:0] as the amount.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts the result.
result  output  WIDTH  primary result (lo for multu).
hi  output  WIDTH  upper product for multu, else 0.
zero  output  1  result == 0.
illegal  output  1  unrecognised funct/opcode in the accepted op.

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; result=0; hi=0; zero=1; illegal=0; multiply counter=0. Reset wins over every other event, including an in-flight multiply, which is abandoned.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE). Accept = in_valid & in_ready. Operands and decoded op are captured on accept.
- IDLE, accept of a single-cycle op: compute, register the outputs, go to DONE. out_valid rises the next cycle (latency 1).
- IDLE, accept of multu: load multiplicand/multiplier, counter=WIDTH, go to BUSY.
- BUSY: one shift-add step per cycle and counter decrements. When counter reaches 1, the final step completes, {hi,result} = a*b (unsigned, 2*WIDTH bits), and the unit goes to DONE. out_valid is high WIDTH cycles after the accept edge.
- DONE: out_valid=1. Outputs are held stable until out_ready=1, then the unit goes to IDLE. There is no same-cycle re-accept, so at most one op is ever in flight.
- in_valid while not ready is ignored; the producer must hold.
- Decode when ALUOp=10, by funct:
  - 100000/100001 add
  - 100010/100011 sub
  - 100100 and
  - 100101 or
  - 100110 xor
  - 100111 nor
  - 101010 slt (signed)
  - 101011 sltu
  - 000000 sll
  - 000010 srl
  - 000011 sra
  - 011001 multu
  - other: add with illegal=1.
- Decode when ALUOp=11, by opcode:
  - 001100 and
  - 001101 or
  - 001110 xor
  - 001010 slt
  - 001011 sltu
  - 001111 lui (b << WIDTH/2)
  - other: add with illegal=1.
- ALUOp=00 is add; ALUOp=01 is sub. illegal=0 for both.
- Arithmetic wraps modulo 2^WIDTH. slt/sltu results are zero-extended 1/0. hi=0 for all non-multu ops.
- zero is computed from the registered result and is valid whenever out_valid=1.

Optional Feature:
ALU_OVF_EN
- Defined: adds output port ovf (1 bit, reset 0). It is set in DONE for signed overflow on add (funct 100000 or ALUOp=00) and sub (funct 100010 or ALUOp=01). addu/subu never flag. When ovf=1, result still carries the wrapped value.
- Undefined: no ovf port and no overflow logic.

Test Plan:
- Reset then add: assert reset for 2 cycles, checking in_ready=1, out_valid=0, result=0, zero=1. Then ALUOp=10, funct=100000, a=5, b=7 -> next cycle out_valid=1, result=12, zero=0, illegal=0.
- Immediates and compares: ALUOp=11, opcode=001110, a=0xFF00FF00, b=0x0F0F0F0F -> result=0xF00FF00F. opcode=001010, a=0xFFFFFFFF, b=1 -> result=1. opcode=001011 with the same operands -> result=0.
- Shifts: funct=000011, a=0x80000000, b=4 -> 0xF8000000. funct=000010 with the same operands -> 0x08000000.
- Multiply with backpressure: funct=011001, a=0xFFFFFFFF, b=2. in_ready=0 throughout BUSY; out_valid after 32 cycles with hi=1, result=0xFFFFFFFE. Hold out_ready=0 for 3 cycles -> outputs stable; out_ready=1 -> IDLE and in_ready=1.
- Illegal decode and reset mid-multiply: funct=111111 -> illegal=1, result=a+b. Start multu, assert reset at BUSY cycle 10 -> next cycle IDLE, out_valid=0, hi=0.
- ALU_OVF_EN: add a=0x7FFFFFFF, b=1 -> ovf=1, result=0x80000000. addu with the same operands -> ovf=0.
